// File: rtl/mips_multicycle.sv
// mips_multicycle: multi-cycle MIPS core with a single shared memory port.
// Each instruction steps through FETCH, DECODE, EXEC, MEM and WB and uses only
// the states it needs. An illegal opcode either stops the core in HALT or
// retires as a NOP, depending on HALT_ON_ILLEGAL.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   mem_req    out  memory access request (instruction fetch or data)
//   mem_we     out  write enable, only ever 1 while mem_req=1
//   mem_addr   out  byte address (PC in FETCH, ALUOut in MEM)
//   mem_wdata  out  store data (rt register value)
//   mem_rdata  in   read data, combinational, valid when mem_ready=1
//   mem_ready  in   the current access completes on this clock edge
//   inst_count out  retired-instruction counter, wraps at 2^CNT_W
//   halted     out  core stopped on an illegal opcode
//   pc_out     out  current PC, for debug
//   dbg_state  out  control FSM state, for debug
//
// Memory handshake: the core raises mem_req with mem_we/mem_addr/mem_wdata
// held constant from a register; the access completes on the first rising
// edge where mem_req=1 and mem_ready=1. The core never drops mem_req or
// changes the request fields before that edge (only reset aborts it).
module mips_multicycle #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          ADDR_W          = 32,
  parameter int          CNT_W           = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  inst_count,
  output logic              halted,
  output logic [31:0]       pc_out,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_pc;
  logic [31:0]      r_ir;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_imm;
  logic [31:0]      r_alu_out;
  logic [31:0]      r_mdr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_rf [32];

  // Instruction fields, always taken from the latched IR.
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_sext;
  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_funct = r_ir[5:0];
  assign w_sext  = {{16{r_ir[15]}}, r_ir[15:0]};
  // r_pc already holds PC+4 once the instruction has been fetched.
  assign w_jump_target   = {r_pc[31:28], r_ir[25:0], 2'b00};
  assign w_branch_target = r_pc + {r_imm[29:0], 2'b00};

  logic w_is_rtype;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_beq;
  logic w_is_addi;
  logic w_is_j;
  logic w_legal;

  always_comb begin
    w_is_rtype = 1'b0;
    if (w_op == OP_RTYPE) begin
      case (w_funct)
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: w_is_rtype = 1'b1;
        default:                               w_is_rtype = 1'b0;
      endcase
    end
  end

  assign w_is_lw   = (w_op == OP_LW);
  assign w_is_sw   = (w_op == OP_SW);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_addi = (w_op == OP_ADDI);
  assign w_is_j    = (w_op == OP_J);
  assign w_legal   = w_is_rtype | w_is_lw | w_is_sw | w_is_beq | w_is_addi | w_is_j;

  // ALU: R-type uses B, everything else that reaches EXEC adds the immediate.
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_res;

  always_comb begin
    w_alu_b   = w_is_rtype ? r_b : r_imm;
    w_alu_res = r_a + w_alu_b;
    if (w_is_rtype) begin
      case (w_funct)
        FN_SUB:  w_alu_res = r_a - w_alu_b;
        FN_AND:  w_alu_res = r_a & w_alu_b;
        FN_OR:   w_alu_res = r_a | w_alu_b;
        FN_SLT:  w_alu_res = {31'd0, ($signed(r_a) < $signed(w_alu_b))};
        default: w_alu_res = r_a + w_alu_b;
      endcase
    end
  end

  // Control strobes produced by the FSM for the datapath registers.
  logic        w_req;
  logic        w_we;
  logic        w_ld_ir;
  logic        w_pc_we;
  logic [31:0] w_pc_d;
  logic        w_ld_ab;
  logic        w_ld_alu;
  logic        w_ld_mdr;
  logic        w_rf_we;
  logic        w_retire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_req    = 1'b0;
    w_we     = 1'b0;
    w_ld_ir  = 1'b0;
    w_pc_we  = 1'b0;
    w_pc_d   = r_pc;
    w_ld_ab  = 1'b0;
    w_ld_alu = 1'b0;
    w_ld_mdr = 1'b0;
    w_rf_we  = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (mem_ready) begin
          w_ld_ir = 1'b1;
          w_pc_we = 1'b1;
          w_pc_d  = r_pc + 32'd4;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        w_ld_ab = 1'b1;
        if (w_is_j) begin
          w_pc_we  = 1'b1;
          w_pc_d   = w_jump_target;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (!w_legal) begin
          if (HALT_ON_ILLEGAL) begin
            w_next = S_HALT;
          end else begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_ld_alu = 1'b1;
        if (w_is_beq) begin
          if (r_a == r_b) begin
            w_pc_we = 1'b1;
            w_pc_d  = w_branch_target;
          end
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_req = 1'b1;
        w_we  = w_is_sw;
        if (mem_ready) begin
          if (w_is_sw) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_ld_mdr = 1'b1;
            w_next   = S_WB;
          end
        end
      end
      S_WB: begin
        w_rf_we  = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
      r_count   <= '0;
    end else begin
      if (w_ld_ir)  r_ir <= mem_rdata;
      if (w_pc_we)  r_pc <= w_pc_d;
      if (w_ld_ab) begin
        r_a   <= r_rf[w_rs];
        r_b   <= r_rf[w_rt];
        r_imm <= w_sext;
      end
      if (w_ld_alu) r_alu_out <= w_alu_res;
      if (w_ld_mdr) r_mdr <= mem_rdata;
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  // Register file: $0 is never written, so it always reads back as 0.
  logic [4:0]  w_wb_dest;
  logic [31:0] w_wb_data;

  assign w_wb_dest = w_is_rtype ? w_rd : w_rt;
  assign w_wb_data = w_is_lw ? r_mdr : r_alu_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_rf_we && (w_wb_dest != 5'd0)) begin
      r_rf[w_wb_dest] <= w_wb_data;
    end
  end

  // Request lines are gated by rst so an in-flight access drops immediately.
  assign mem_req    = w_req & rst;
  assign mem_we     = w_we & rst;
  assign mem_addr   = (r_state == S_MEM) ? r_alu_out[ADDR_W-1:0] : r_pc[ADDR_W-1:0];
  assign mem_wdata  = r_b;
  assign inst_count = r_count;
  assign halted     = (r_state == S_HALT);
  assign pc_out     = r_pc;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mips_multicycle.sv
// Self-checking bench for mips_multicycle: an instruction-level model predicts
// the memory access stream, PC, retire count and latency; a negedge process
// acts as the wait-state memory and compares every request against it.
module tb_mips_multicycle;

  localparam bit TB_HALT = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] inst_count;
  logic        halted;
  logic [31:0] pc_out;
  logic [2:0]  dut_state;

  mips_multicycle u_dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .inst_count (inst_count),
    .halted     (halted),
    .pc_out     (pc_out),
    .dbg_state  (dut_state)
  );

  // ---------------- NOP-on-illegal instance, zero-wait memory ----------------
  logic        rst_nop = 1'b0;
  logic        nop_req;
  logic        nop_we;
  logic [31:0] nop_addr;
  logic [31:0] nop_wdata;
  logic [31:0] nop_rdata;
  logic [31:0] nop_count;
  logic        nop_halted;
  logic [31:0] nop_pc;
  logic [2:0]  nop_state;
  logic [31:0] nop_mem [16];

  assign nop_rdata = nop_mem[nop_addr[5:2]];

  mips_multicycle #(.HALT_ON_ILLEGAL(1'b0)) u_nop (
    .clk        (clk),
    .rst        (rst_nop),
    .mem_req    (nop_req),
    .mem_we     (nop_we),
    .mem_addr   (nop_addr),
    .mem_wdata  (nop_wdata),
    .mem_rdata  (nop_rdata),
    .mem_ready  (1'b1),
    .inst_count (nop_count),
    .halted     (nop_halted),
    .pc_out     (nop_pc),
    .dbg_state  (nop_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memories and model ----------------
  logic [31:0] dut_mem [1024];
  logic [31:0] m_mem   [1024];
  logic [31:0] m_rf    [32];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_halted;
  int          m_lat;
  int          lat_hist [64];
  logic [3:0]  fetch_stall = 4'd0;
  logic [3:0]  data_stall  = 4'd0;
  logic        cmp_en      = 1'b0;

  // Expected access: {we, stall[3:0], addr[31:0], wdata[31:0]}
  logic [68:0] exp_q [$];

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    m_mem[addr[11:2]]   = word;
    dut_mem[addr[11:2]] = word;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) begin
      m_mem[i]   = '0;
      dut_mem[i] = '0;
    end
    put(32'h000, 32'h2001_0005); // addi $1,$0,5
    put(32'h004, 32'h2002_0007); // addi $2,$0,7
    put(32'h008, 32'h0022_1820); // add  $3,$1,$2
    put(32'h00C, 32'hAC03_0040); // sw   $3,0x40($0)
    put(32'h010, 32'h1021_0002); // beq  $1,$1,+2 -> 0x1C
    put(32'h014, 32'h2009_0001); // addi $9,$0,1 (skipped)
    put(32'h018, 32'h2009_0002); // addi $9,$0,2 (skipped)
    put(32'h01C, 32'h1022_0002); // beq  $1,$2,+2 (not taken)
    put(32'h020, 32'h0800_0100); // j    0x100 -> 0x400
    put(32'h400, 32'h8C04_0040); // lw   $4,0x40($0)
    put(32'h404, 32'hAC04_0044); // sw   $4,0x44($0)
    put(32'h408, 32'h2000_0009); // addi $0,$0,9
    put(32'h40C, 32'hAC00_0048); // sw   $0,0x48($0)
    put(32'h410, 32'h0022_2822); // sub  $5,$1,$2
    put(32'h414, 32'h00A1_302A); // slt  $6,$5,$1
    put(32'h418, 32'h0022_4024); // and  $8,$1,$2
    put(32'h41C, 32'h0022_5025); // or   $10,$1,$2
    put(32'h420, 32'hAC05_004C); // sw   $5,0x4C($0)
    put(32'h424, 32'hAC06_0050); // sw   $6,0x50($0)
    put(32'h428, 32'hAC08_0054); // sw   $8,0x54($0)
    put(32'h42C, 32'hAC0A_0058); // sw   $10,0x58($0)
    put(32'h430, 32'hFC00_0000); // opcode 0x3F, illegal
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc     = 32'h0;
    m_cnt    = 32'h0;
    m_halted = 1'b0;
  endtask

  // Executes one instruction architecturally; queues its expected memory
  // accesses and records its cycle cost from the latency table plus stalls.
  task automatic model_step(input int idx);
    logic [31:0] ins, a, b, simm, addr, npc, res;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    bit          ill;
    int          lat;
    ins  = m_mem[m_pc[11:2]];
    op   = ins[31:26];
    rs   = ins[25:21];
    rt   = ins[20:16];
    rd   = ins[15:11];
    fn   = ins[5:0];
    simm = {{16{ins[15]}}, ins[15:0]};
    a    = m_rf[rs];
    b    = m_rf[rt];
    addr = a + simm;
    npc  = m_pc + 32'd4;
    ill  = 1'b0;
    lat  = 0;
    res  = '0;
    exp_q.push_back({1'b0, fetch_stall, m_pc, 32'h0});
    case (op)
      6'h00: begin
        lat = 4;
        case (fn)
          6'h20:   res = a + b;
          6'h22:   res = a - b;
          6'h24:   res = a & b;
          6'h25:   res = a | b;
          6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: ill = 1'b1;
        endcase
        if (!ill) m_rf[rd] = res;
      end
      6'h08: begin
        lat = 4;
        m_rf[rt] = a + simm;
      end
      6'h23: begin
        lat = 5 + int'(data_stall);
        exp_q.push_back({1'b0, data_stall, addr, 32'h0});
        m_rf[rt] = m_mem[addr[11:2]];
      end
      6'h2B: begin
        lat = 4 + int'(data_stall);
        exp_q.push_back({1'b1, data_stall, addr, b});
        m_mem[addr[11:2]] = b;
      end
      6'h04: begin
        lat = 3;
        if (a == b) npc = npc + (simm << 2);
      end
      6'h02: begin
        lat = 2;
        npc = {npc[31:28], ins[25:0], 2'b00};
      end
      default: ill = 1'b1;
    endcase
    m_rf[0] = '0;
    if (ill) lat = 2;
    lat = lat + int'(fetch_stall);
    m_pc = npc;
    if (ill && TB_HALT) m_halted = 1'b1;
    else                m_cnt = m_cnt + 32'd1;
    m_lat = lat;
    lat_hist[idx] = lat;
  endtask

  // ---------------- wait-state memory + per-cycle compare ----------------
  int wcnt = 0;

  always @(negedge clk) begin
    logic [68:0] e;
    mem_ready = 1'b0;
    if (!rst || !cmp_en) begin
      wcnt = 0;
    end else begin
      if (!mem_req) check("we_without_req", {31'd0, mem_we}, 32'd0);
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_req: got addr %h we %b, expected no request (t=%0t)",
                   mem_addr, mem_we, $time);
        end else begin
          e = exp_q[0];
          check("acc_we",   {31'd0, mem_we}, {31'd0, e[68]});
          check("acc_addr", mem_addr, e[63:32]);
          if (e[68]) check("acc_wdata", mem_wdata, e[31:0]);
          if (wcnt < int'(e[67:64])) begin
            wcnt++;
          end else begin
            mem_ready = 1'b1;
            mem_rdata = dut_mem[mem_addr[11:2]];
            if (mem_we) dut_mem[mem_addr[11:2]] = mem_wdata;
            void'(exp_q.pop_front());
            wcnt = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Resets, runs n instructions from RESET_PC and checks retire timing.
  task automatic run_phase(input int n, input logic [3:0] fs, input logic [3:0] ds,
                           output int cyc);
    logic [31:0] prev_cnt;
    rst    = 1'b0;
    cmp_en = 1'b0;
    exp_q.delete();
    fetch_stall = fs;
    data_stall  = ds;
    load_prog();
    model_reset();
    cyc      = 0;
    prev_cnt = 0;
    for (int i = 0; i < n; i++) begin
      prev_cnt = m_cnt;
      model_step(i);
      cyc += m_lat;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    repeat (cyc - 1) @(posedge clk);
    #2 check("cnt_before_retire", inst_count, prev_cnt);
    @(posedge clk);
    #2;
    check("inst_count", inst_count, m_cnt);
    check("pc_out",     pc_out,     m_pc);
    check("halted",     {31'd0, halted}, {31'd0, m_halted});
    check("queue_drained", exp_q.size(), 32'd0);
    cmp_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int lat_pre;

    // HALT_ON_ILLEGAL=0: illegal opcode and unlisted funct both act as NOPs.
    for (int i = 0; i < 16; i++) nop_mem[i] = '0;
    nop_mem[0] = 32'hFC00_0000; // opcode 0x3F
    nop_mem[1] = 32'h0000_0000; // R-type funct 0x00, not supported
    nop_mem[2] = 32'h2001_0003; // addi $1,$0,3
    @(posedge clk);
    #1 check("nop_reset_pc", nop_pc, 32'h0);
    rst_nop = 1'b1;
    repeat (2) @(posedge clk);
    #2 check("nop_cnt_1", nop_count, 32'd1);
    check("nop_pc_1", nop_pc, 32'h4);
    repeat (2) @(posedge clk);
    #2 check("nop_cnt_2", nop_count, 32'd2);
    check("nop_pc_2", nop_pc, 32'h8);
    repeat (4) @(posedge clk);
    #2 check("nop_cnt_3", nop_count, 32'd3);
    check("nop_pc_3", nop_pc, 32'hC);
    check("nop_not_halted", {31'd0, nop_halted}, 32'd0);

    // Reset values while held in reset.
    #1 check("rst_req",    {31'd0, mem_req}, 32'd0);
    check("rst_we",        {31'd0, mem_we},  32'd0);
    check("rst_pc",        pc_out,          32'h0);
    check("rst_cnt",       inst_count,      32'd0);
    check("rst_halted",    {31'd0, halted}, 32'd0);

    // addi, addi, add: 12 cycles, 3 retired, PC 0x0C.
    run_phase(3, 4'd0, 4'd0, cyc);
    check("p1_cycles", cyc, 32'd12);
    check("p1_cnt_lit", inst_count, 32'd3);
    check("p1_pc_lit",  pc_out,     32'h0C);

    // Taken beq at 0x10 -> 0x1C.
    run_phase(5, 4'd0, 4'd0, cyc);
    check("beq_taken_pc", pc_out, 32'h1C);
    check("beq_lat", lat_hist[4], 32'd3);

    // Untaken beq at 0x1C -> PC+4.
    run_phase(6, 4'd0, 4'd0, cyc);
    check("beq_untaken_pc", pc_out, 32'h20);

    // j 0x100 at 0x20 -> 0x400.
    run_phase(7, 4'd0, 4'd0, cyc);
    check("j_pc", pc_out, 32'h400);
    check("j_cnt", inst_count, 32'd7);
    check("j_lat", lat_hist[6], 32'd2);

    // Whole legal program with 3 wait states on every data access.
    run_phase(19, 4'd0, 4'd3, cyc);
    check("lw_lat", lat_hist[7], 32'd8);
    check("sw_lat", lat_hist[3], 32'd7);
    check("mem_40", dut_mem[16], 32'd12);
    check("mem_44_lw", dut_mem[17], 32'd12);
    check("mem_48_r0", dut_mem[18], 32'd0);
    check("mem_4c_sub", dut_mem[19], 32'hFFFF_FFFE);
    check("mem_50_slt", dut_mem[20], 32'd1);
    check("mem_54_and", dut_mem[21], 32'd5);
    check("mem_58_or",  dut_mem[22], 32'd7);

    // Same program with fetch stalls as well.
    run_phase(19, 4'd2, 4'd1, cyc);

    // Illegal opcode halts; nothing more is requested or retired.
    run_phase(20, 4'd0, 4'd0, cyc);
    cmp_en = 1'b1;
    repeat (20) @(posedge clk);
    #2 check("halt_cnt_frozen", inst_count, 32'd19);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_no_req", {31'd0, mem_req}, 32'd0);
    check("halt_pc", pc_out, 32'h434);
    cmp_en = 1'b0;

    // Reset during a stalled lw MEM phase.
    rst = 1'b0;
    exp_q.delete();
    fetch_stall = 4'd0;
    data_stall  = 4'd10;
    load_prog();
    model_reset();
    lat_pre = 0;
    for (int i = 0; i < 7; i++) begin
      model_step(i);
      lat_pre += m_lat;
    end
    model_step(7);
    @(posedge clk);
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    repeat (lat_pre + 4) @(posedge clk);
    #2 check("midlw_req", {31'd0, mem_req}, 32'd1);
    check("midlw_addr", mem_addr, 32'h40);
    check("midlw_cnt", inst_count, 32'd7);
    rst = 1'b0;
    #1 check("abort_req", {31'd0, mem_req}, 32'd0);
    check("abort_we",     {31'd0, mem_we},  32'd0);
    check("abort_pc",     pc_out,          32'h0);
    check("abort_cnt",    inst_count,      32'd0);
    check("abort_halted", {31'd0, halted}, 32'd0);
    cmp_en = 1'b0;

    // Restart from RESET_PC after the aborted access.
    run_phase(4, 4'd1, 4'd0, cyc);
    check("restart_pc", pc_out, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle.md
Name: mips_multicycle

Overview:
- Multi-cycle MIPS core; the next-generation successor to the single-cycle top.
- One shared memory port carries both instruction fetch and data access, with a req/ready handshake so wait-state memories can stall the core.
- Contains its own control FSM, regfile, ALU, PC and IR. Adds a retired-instruction counter and a halt-on-illegal-opcode mode.
- Sits under the SoC top in place of the single-cycle core, driving the unified block RAM.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, width of mem_addr; PC[ADDR_W-1:0] and ALU result[ADDR_W-1:0] are driven out
CNT_W, 32, width of inst_count
HALT_ON_ILLEGAL, 1, 1: illegal opcode enters HALT; 0: illegal opcode is treated as NOP

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
mem_req  output  1  memory access request
mem_we  output  1  write enable, valid while mem_req=1
mem_addr  output  ADDR_W  byte address
mem_wdata  output  32  store data (rt)
mem_rdata  input  32  read data, combinational, valid when mem_ready=1
mem_ready  input  1  access completes this cycle
inst_count  output  CNT_W  retired-instruction counter
halted  output  1  core stopped on illegal opcode
pc_out  output  32  current PC, for debug

Behaviour:
- Supported instructions: R-type add, sub, and, or, slt (funct 20,22,24,25,2A hex); lw (23); sw (2B); beq (04); addi (08); j (02). Any other op, or an unlisted funct, is illegal.
- Arithmetic:
  - 32-bit wrap-around; no overflow traps.
  - slt is signed.
  - Immediates are sign-extended.
  - Branch target = PC+4 + (sext(imm)<<2).
  - Jump target = {PC+4[31:28], imm26, 2'b00}.
- Register file: 32x32; $0 always reads 0 and writes to it are dropped; 2 combinational reads, 1 synchronous write.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. Stays in FETCH while mem_ready=0. When mem_ready=1: IR<=mem_rdata, PC<=PC+4, go to DECODE.
  - DECODE: latch A=rs, B=rt and sext(imm).
    - j: PC<=target, retire, go to FETCH.
    - illegal: go to HALT (HALT_ON_ILLEGAL=1), or retire as NOP and go to FETCH (0).
    - otherwise go to EXEC.
  - EXEC: ALU computes and the result is latched as ALUOut.
    - beq: if A==B then PC<=branch target; retire either way; go to FETCH.
    - lw/sw: go to MEM.
    - R-type/addi: go to WB.
  - MEM: mem_req=1, mem_addr=ALUOut, mem_we=1 for sw with mem_wdata=B. Stays in MEM while mem_ready=0.
    - On mem_ready=1, sw: retire, go to FETCH.
    - On mem_ready=1, lw: MDR<=mem_rdata, go to WB.
  - WB: write rd (R-type) or rt (addi/lw), taking ALUOut or MDR. Retire, go to FETCH.
  - HALT: terminal; halted=1, mem_req=0. Only reset leaves HALT.
- Latency with zero wait states: j 2 cycles; beq 3; R-type/addi/sw 4; lw 5. Each stalled cycle in FETCH or MEM adds 1.
- Retire: inst_count increments by 1 on the retiring edge and wraps at 2^CNT_W.
- mem_req is 0 in DECODE, EXEC, WB and HALT. mem_we=0 whenever mem_req=0. mem_addr and mem_wdata hold stable while a request is stalled.
- Reset (rst=0, asynchronous):
  - state=FETCH, PC=RESET_PC, IR=0, inst_count=0, halted=0, all regfile entries 0.
  - Outputs during reset: mem_req=0, mem_we=0.
  - A reset asserted mid-access (FETCH or MEM) aborts the access. The regfile and PC are not updated by the aborted instruction.
- First cycle after reset is released: FETCH with mem_req=1 and mem_addr=RESET_PC.

Test Plan:
- Reset, memory with no wait states, program: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 -> $3=12, inst_count=3 after 12 cycles, pc_out=0x0C.
- sw $3,0x40($0) then lw $4,0x40($0), with mem_ready held low for 3 cycles in each MEM -> write seen with addr 0x40 and data 12, addr and data stable throughout the stall; $4=12; lw takes 5+3 cycles.
- beq $1,$1,+2 at PC 0x10 -> PC=0x1C after 3 cycles. The same test with unequal registers -> PC=0x14.
- j 0x100 at PC 0x20 -> PC=0x400 after 2 cycles; inst_count +1.
- Opcode 0x3F with HALT_ON_ILLEGAL=1 -> halted=1, mem_req=0 thereafter, inst_count frozen. With HALT_ON_ILLEGAL=0 -> treated as NOP, PC advances by 4.
- rst pulsed low during a stalled lw MEM phase -> all outputs at reset values within the same cycle; destination register unchanged; FETCH restarts at RESET_PC.
- addi $0,$0,9 -> $0 still reads 0.
